// File: rtl/mem_port_arbiter.sv
// Shared RAM port arbiter: I-cache refills vs D-cache refills/write-throughs.
// Optional ARB_ROUND_ROBIN_EN: alternate grants under contention.
module mem_port_arbiter #(
    parameter int RAM_LATENCY = 4,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              iic_req,
    input  logic [ADDR_W-1:0] iic_addr,
    input  logic              idc_rd_req,
    input  logic              idc_wr_req,
    input  logic [ADDR_W-1:0] idc_addr,
    input  logic [31:0]       idc_wdata,
    output logic              oic_done,
    output logic              odc_done,
    output logic [127:0]      oline,
    output logic              obusy,
    output logic [ADDR_W-1:0] oram_addr,
    output logic [31:0]       oram_wdata,
    output logic              oram_re,
    output logic              oram_we,
    input  logic [127:0]      iram_rdata
);

    localparam int CW = $clog2(RAM_LATENCY) + 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(RAM_LATENCY - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          owner_dc;
    logic          dc_any;
    logic          grant_dc;

    assign dc_any = idc_rd_req | idc_wr_req;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_dc;

    // Under contention the side not granted last time wins.
    always_comb begin
        grant_dc = dc_any && (!iic_req || !last_dc);
    end

    // Remember who won the most recent grant.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_dc <= 1'b0;
        end else if (state == IDLE && (iic_req || dc_any)) begin
            last_dc <= grant_dc;
        end
    end
`else
    // The MEM stage is older than IF, so the D-cache always wins.
    always_comb begin
        grant_dc = dc_any;
    end
`endif

    // Transfer sequencer: grant, hold the strobe RAM_LATENCY cycles, pulse done.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            cnt        <= '0;
            owner_dc   <= 1'b0;
            oic_done   <= 1'b0;
            odc_done   <= 1'b0;
            oline      <= '0;
            obusy      <= 1'b0;
            oram_addr  <= '0;
            oram_wdata <= '0;
            oram_re    <= 1'b0;
            oram_we    <= 1'b0;
        end else begin
            oic_done <= 1'b0;
            odc_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (iic_req || dc_any) begin
                        owner_dc   <= grant_dc;
                        cnt        <= CNT_LOAD;
                        obusy      <= 1'b1;
                        oram_wdata <= idc_wdata;
                        if (grant_dc && idc_wr_req) begin
                            state     <= WRITE;
                            oram_we   <= 1'b1;
                            oram_addr <= idc_addr;
                        end else if (grant_dc) begin
                            state     <= READ;
                            oram_re   <= 1'b1;
                            oram_addr <= {idc_addr[ADDR_W-1:4], 4'b0};
                        end else begin
                            state     <= READ;
                            oram_re   <= 1'b1;
                            oram_addr <= {iic_addr[ADDR_W-1:4], 4'b0};
                        end
                    end
                end
                READ, WRITE: begin
                    if (cnt == '0) begin
                        state   <= DONE;
                        oram_re <= 1'b0;
                        oram_we <= 1'b0;
                        if (state == READ) begin
                            oline <= iram_rdata;
                        end
                        if (owner_dc) begin
                            odc_done <= 1'b1;
                        end else begin
                            oic_done <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    obusy <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter, RAM_LATENCY=4.
// Covers ARB_ROUND_ROBIN_EN contention when the macro is defined.
module tb_mem_port_arbiter;

    logic         clk = 1'b0;
    logic         rstn;
    logic         iic_req;
    logic [31:0]  iic_addr;
    logic         idc_rd_req;
    logic         idc_wr_req;
    logic [31:0]  idc_addr;
    logic [31:0]  idc_wdata;
    logic         oic_done;
    logic         odc_done;
    logic [127:0] oline;
    logic         obusy;
    logic [31:0]  oram_addr;
    logic [31:0]  oram_wdata;
    logic         oram_re;
    logic         oram_we;
    logic [127:0] iram_rdata;

    mem_port_arbiter #(.RAM_LATENCY(4), .ADDR_W(32)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .iic_req    (iic_req),
        .iic_addr   (iic_addr),
        .idc_rd_req (idc_rd_req),
        .idc_wr_req (idc_wr_req),
        .idc_addr   (idc_addr),
        .idc_wdata  (idc_wdata),
        .oic_done   (oic_done),
        .odc_done   (odc_done),
        .oline      (oline),
        .obusy      (obusy),
        .oram_addr  (oram_addr),
        .oram_wdata (oram_wdata),
        .oram_re    (oram_re),
        .oram_we    (oram_we),
        .iram_rdata (iram_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           dc;
        logic [127:0] line;
        int           cyc;
    } exp_t;

    exp_t         q[$];
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;
    int           g;
    logic [127:0] exp_line = '0;

    function automatic logic [127:0] ram_line(input logic [31:0] a);
        return {a ^ 32'hA5A5_0000, ~a, a + 32'h0000_1111, {a[15:0], a[31:16]}};
    endfunction

    assign iram_rdata = ram_line(oram_addr);

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [127:0] act,
                                input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    // Monitor: every done pulse is matched against the next expected completion.
    always @(negedge clk) begin
        if (oic_done || odc_done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", {oic_done, odc_done}, 2'b00);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("done_ic", oic_done, !e.dc);
                chk("done_dc", odc_done, e.dc);
                chk("done_cycle", cyc, e.cyc);
                chk("done_line", oline, e.line);
            end
        end
    end

    function automatic void push(input bit dc, input logic [127:0] line, input int c);
        exp_t e;
        e.dc = dc;
        e.line = line;
        e.cyc = c;
        q.push_back(e);
    endfunction

    // kind: 0 IC read, 1 DC read, 2 DC write, 3 DC read+write (illegal)
    task automatic run_one(input int kind, input logic [31:0] a, input logic [31:0] d);
        int gc;
        logic [31:0] ea;
        bit wr;
        wr = (kind >= 2);
        @(negedge clk);
        if (kind == 0) begin
            iic_req = 1'b1;
            iic_addr = a;
        end else begin
            idc_rd_req = (kind == 1 || kind == 3);
            idc_wr_req = wr;
            idc_addr = a;
            idc_wdata = d;
        end
        @(posedge clk);
        #1;
        gc = cyc;
        ea = wr ? a : {a[31:4], 4'b0};
        if (!wr) exp_line = ram_line(ea);
        push(kind != 0, exp_line, gc + 4);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("strobe_re", oram_re, !wr);
            chk("strobe_we", oram_we, wr);
            chk("ram_addr", oram_addr, ea);
            chk("busy", obusy, 1'b1);
            if (wr) chk("ram_wdata", oram_wdata, d);
        end
        @(negedge clk);
        chk("strobe_off", {oram_re, oram_we}, 2'b00);
        iic_req = 1'b0;
        idc_rd_req = 1'b0;
        idc_wr_req = 1'b0;
    endtask

    initial begin
        rstn = 1'b0;
        iic_req = 1'b0;
        iic_addr = '0;
        idc_rd_req = 1'b0;
        idc_wr_req = 1'b0;
        idc_addr = '0;
        idc_wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", obusy, 1'b0);
        chk("rst_done", {oic_done, odc_done}, 2'b00);
        chk("rst_strobes", {oram_re, oram_we}, 2'b00);
        chk("rst_line", oline, 128'h0);
        chk("rst_addr", oram_addr, 32'h0);
        chk("rst_wdata", oram_wdata, 32'h0);
        rstn = 1'b1;

        run_one(0, 32'h0000_1234, 32'h0);

`ifdef ARB_ROUND_ROBIN_EN
        @(negedge clk);
        iic_req = 1'b1;
        iic_addr = 32'h0000_3340;
        idc_rd_req = 1'b1;
        idc_addr = 32'h0000_5578;
        @(posedge clk);
        #1;
        g = cyc;
        push(1'b1, ram_line(32'h0000_5570), g + 4);
        push(1'b0, ram_line(32'h0000_3340), g + 10);
        push(1'b1, ram_line(32'h0000_5570), g + 16);
        push(1'b0, ram_line(32'h0000_3340), g + 22);
        repeat (23) @(negedge clk);
        iic_req = 1'b0;
        idc_rd_req = 1'b0;
        exp_line = ram_line(32'h0000_3340);
`else
        @(negedge clk);
        iic_req = 1'b1;
        iic_addr = 32'h0000_3340;
        idc_rd_req = 1'b1;
        idc_addr = 32'h0000_5578;
        @(posedge clk);
        #1;
        g = cyc;
        push(1'b1, ram_line(32'h0000_5570), g + 4);
        push(1'b0, ram_line(32'h0000_3340), g + 10);
        @(negedge clk);
        chk("prio_addr_dc", oram_addr, 32'h0000_5570);
        repeat (4) @(negedge clk);
        idc_rd_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("prio_addr_ic", oram_addr, 32'h0000_3340);
        chk("prio_re_ic", oram_re, 1'b1);
        repeat (4) @(negedge clk);
        iic_req = 1'b0;
        exp_line = ram_line(32'h0000_3340);
`endif

        run_one(2, 32'h0000_0048, 32'hDEAD_BEEF);

        @(negedge clk);
        iic_req = 1'b1;
        iic_addr = 32'h0000_7A0C;
        @(posedge clk);
        #1;
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("arst_busy", obusy, 1'b0);
        chk("arst_re", oram_re, 1'b0);
        chk("arst_addr", oram_addr, 32'h0);
        chk("arst_line", oline, 128'h0);
        exp_line = '0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        g = cyc;
        exp_line = ram_line(32'h0000_7A00);
        push(1'b0, exp_line, g + 4);
        repeat (5) @(negedge clk);
        iic_req = 1'b0;

        run_one(3, 32'h0000_0064, 32'h1234_5678);
        run_one(1, 32'h0000_2ABC, 32'h0);

        repeat (4) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
